// File: rtl/rec_play_pkg.sv
// Shared types for the record/playback controller: FSM states and playback modes.
`timescale 1ns/1ps
package rec_play_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        REC        = 3'd2,
        REC_PAUSE  = 3'd3,
        PLAY       = 3'd4,
        PLAY_PAUSE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        SLOW0  = 2'd2,
        SLOW1  = 2'd3
    } mode_e;

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchroniser, stability counter, one-cycle press event.
`timescale 1ns/1ps
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             lvl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Any sample matching the accepted level restarts the stability window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= 2'b11;
            lvl_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            press_q <= 1'b0;
            if (sync_q[1] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                lvl_q   <= sync_q[1];
                cnt_q   <= '0;
                press_q <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback key FSM: per-slot SRAM regions, record pause, latched play mode and speed.
`timescale 1ns/1ps
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_W     = $clog2(NUM_SLOTS),
    parameter int SPEED_W    = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_key_rec,
    input  logic                 i_key_play,
    input  logic                 i_key_stop,
    input  logic                 i_init_done,
    input  logic [SLOT_W-1:0]    i_slot_sel,
    input  logic [1:0]           i_mode,
    input  logic [SPEED_W-1:0]   i_speed,
    input  logic [ADDR_W-1:0]    i_rec_addr,
    input  logic [ADDR_W-1:0]    i_play_addr,
    output logic [2:0]           o_state,
    output logic                 o_rec_start,
    output logic                 o_rec_stop,
    output logic                 o_rec_pause,
    output logic                 o_play_start,
    output logic                 o_play_stop,
    output logic                 o_play_en,
    output logic                 o_play_fast,
    output logic                 o_play_slow0,
    output logic                 o_play_slow1,
    output logic [SPEED_W-1:0]   o_speed,
    output logic [ADDR_W-1:0]    o_base_addr,
    output logic [ADDR_W-1:0]    o_end_addr,
    output logic                 o_sram_wr,
    output logic [NUM_SLOTS-1:0] o_slot_valid
);
    localparam int REG_W = ADDR_W - SLOT_W;

    logic ev_rec, ev_play, ev_stop;
    logic stop_ev, rec_ev, play_ev;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rec (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .key_n_i(i_key_rec), .press_o(ev_rec));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .key_n_i(i_key_play), .press_o(ev_play));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .key_n_i(i_key_stop), .press_o(ev_stop));

    assign stop_ev = ev_stop;
    assign rec_ev  = ev_rec & ~ev_stop;
    assign play_ev = ev_play & ~ev_stop & ~ev_rec;

    state_e                           state_q;
    logic [SLOT_W-1:0]                slot_q;
    logic [NUM_SLOTS-1:0][ADDR_W-1:0] end_q;
    logic [NUM_SLOTS-1:0]             valid_q;
    logic                             rec_start_q, rec_stop_q, rec_pause_q;
    logic                             play_start_q, play_stop_q, play_en_q;
    logic                             fast_q, slow0_q, slow1_q;
    logic [SPEED_W-1:0]               speed_q;
    logic [ADDR_W-1:0]                base_q, end_out_q;
    logic                             sram_wr_q;

    // Slot regions are power-of-2 aligned, so base/last are plain concatenations.
    logic [ADDR_W-1:0]  sel_base, sel_last, cur_base, cur_last, rec_end_val;
    logic               rec_auto, play_auto;
    mode_e              mode_in;
    logic [SPEED_W-1:0] speed_val;

    assign sel_base    = {i_slot_sel, {REG_W{1'b0}}};
    assign sel_last    = {i_slot_sel, {REG_W{1'b1}}};
    assign cur_base    = {slot_q, {REG_W{1'b0}}};
    assign cur_last    = {slot_q, {REG_W{1'b1}}};
    assign rec_auto    = (state_q == REC) && (i_rec_addr == cur_last);
    assign rec_end_val = rec_auto ? cur_last : i_rec_addr;
    assign play_auto   = (state_q == PLAY) && (i_play_addr >= end_q[slot_q]);
    assign mode_in     = mode_e'(i_mode);
    assign speed_val   = (mode_in == NORMAL || i_speed == '0) ? SPEED_W'(1) : i_speed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= INIT;
            slot_q       <= '0;
            end_q        <= '0;
            valid_q      <= '0;
            rec_start_q  <= 1'b0;
            rec_stop_q   <= 1'b0;
            rec_pause_q  <= 1'b0;
            play_start_q <= 1'b0;
            play_stop_q  <= 1'b0;
            play_en_q    <= 1'b0;
            fast_q       <= 1'b0;
            slow0_q      <= 1'b0;
            slow1_q      <= 1'b0;
            speed_q      <= '0;
            base_q       <= '0;
            end_out_q    <= '0;
            sram_wr_q    <= 1'b0;
        end else begin
            rec_start_q  <= 1'b0;
            rec_stop_q   <= 1'b0;
            play_start_q <= 1'b0;
            play_stop_q  <= 1'b0;
            case (state_q)
                INIT: if (i_init_done) state_q <= IDLE;
                IDLE: begin
                    if (rec_ev) begin
                        state_q     <= REC;
                        slot_q      <= i_slot_sel;
                        rec_start_q <= 1'b1;
                        base_q      <= sel_base;
                        end_out_q   <= sel_last;
                        sram_wr_q   <= 1'b1;
                    end else if (play_ev && valid_q[i_slot_sel]) begin
                        state_q      <= PLAY;
                        slot_q       <= i_slot_sel;
                        play_start_q <= 1'b1;
                        play_en_q    <= 1'b1;
                        base_q       <= sel_base;
                        end_out_q    <= end_q[i_slot_sel];
                        fast_q       <= (mode_in == FAST);
                        slow0_q      <= (mode_in == SLOW0);
                        slow1_q      <= (mode_in == SLOW1);
                        speed_q      <= speed_val;
                    end
                end
                REC, REC_PAUSE: begin
                    if (stop_ev || rec_auto) begin
                        state_q        <= IDLE;
                        rec_stop_q     <= 1'b1;
                        rec_pause_q    <= 1'b0;
                        sram_wr_q      <= 1'b0;
                        end_q[slot_q]  <= rec_end_val;
                        if (rec_end_val != cur_base) valid_q[slot_q] <= 1'b1;
                    end else if (rec_ev) begin
                        state_q     <= (state_q == REC) ? REC_PAUSE : REC;
                        rec_pause_q <= (state_q == REC);
                        sram_wr_q   <= (state_q != REC);
                    end
                end
                PLAY, PLAY_PAUSE: begin
                    if (stop_ev || play_auto) begin
                        state_q     <= IDLE;
                        play_stop_q <= 1'b1;
                        play_en_q   <= 1'b0;
                        fast_q      <= 1'b0;
                        slow0_q     <= 1'b0;
                        slow1_q     <= 1'b0;
                    end else if (play_ev) begin
                        if (state_q == PLAY) begin
                            state_q   <= PLAY_PAUSE;
                            play_en_q <= 1'b0;
                        end else begin
                            state_q   <= PLAY;
                            play_en_q <= 1'b1;
                            fast_q    <= (mode_in == FAST);
                            slow0_q   <= (mode_in == SLOW0);
                            slow1_q   <= (mode_in == SLOW1);
                            speed_q   <= speed_val;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign o_state      = state_q;
    assign o_rec_start  = rec_start_q;
    assign o_rec_stop   = rec_stop_q;
    assign o_rec_pause  = rec_pause_q;
    assign o_play_start = play_start_q;
    assign o_play_stop  = play_stop_q;
    assign o_play_en    = play_en_q;
    assign o_play_fast  = fast_q;
    assign o_play_slow0 = slow0_q;
    assign o_play_slow1 = slow1_q;
    assign o_speed      = speed_q;
    assign o_base_addr  = base_q;
    assign o_end_addr   = end_out_q;
    assign o_sram_wr    = sram_wr_q;
    assign o_slot_valid = valid_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl with 8-bit addresses, 4 slots and a 4-cycle debounce.
`timescale 1ns/1ps
module tb_rec_play_ctrl;
    localparam int AW = 8;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int PW = 4;
    localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_REC = 3'd2,
                           S_RPAUSE = 3'd3, S_PLAY = 3'd4, S_PPAUSE = 3'd5;

    logic i_clk, i_rst_n, i_key_rec, i_key_play, i_key_stop, i_init_done;
    logic [SW-1:0] i_slot_sel;
    logic [1:0]    i_mode;
    logic [PW-1:0] i_speed;
    logic [AW-1:0] i_rec_addr, i_play_addr;
    logic [2:0]    o_state;
    logic o_rec_start, o_rec_stop, o_rec_pause, o_play_start, o_play_stop, o_play_en;
    logic o_play_fast, o_play_slow0, o_play_slow1, o_sram_wr;
    logic [PW-1:0] o_speed;
    logic [AW-1:0] o_base_addr, o_end_addr;
    logic [NS-1:0] o_slot_valid;

    rec_play_ctrl #(.ADDR_W(AW), .NUM_SLOTS(NS), .SLOT_W(SW), .SPEED_W(PW), .DEB_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_rec(i_key_rec), .i_key_play(i_key_play),
        .i_key_stop(i_key_stop), .i_init_done(i_init_done), .i_slot_sel(i_slot_sel),
        .i_mode(i_mode), .i_speed(i_speed), .i_rec_addr(i_rec_addr), .i_play_addr(i_play_addr),
        .o_state(o_state), .o_rec_start(o_rec_start), .o_rec_stop(o_rec_stop),
        .o_rec_pause(o_rec_pause), .o_play_start(o_play_start), .o_play_stop(o_play_stop),
        .o_play_en(o_play_en), .o_play_fast(o_play_fast), .o_play_slow0(o_play_slow0),
        .o_play_slow1(o_play_slow1), .o_speed(o_speed), .o_base_addr(o_base_addr),
        .o_end_addr(o_end_addr), .o_sram_wr(o_sram_wr), .o_slot_valid(o_slot_valid));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int n_rs = 0, n_rp = 0, n_ps = 0, n_pp = 0;
    int b_rs, b_rp, b_ps, b_pp;
    logic [AW-1:0] stop_at;

    always @(negedge i_clk) begin
        if (o_rec_start)  n_rs++;
        if (o_rec_stop)   n_rp++;
        if (o_play_start) n_ps++;
        if (o_play_stop)  n_pp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rs = n_rs; b_rp = n_rp; b_ps = n_ps; b_pp = n_pp;
    endtask

    // Hold the selected keys for 10 cycles, then release long enough to re-debounce high.
    task automatic press(input logic r, input logic p, input logic s);
        @(negedge i_clk);
        i_key_rec = ~r; i_key_play = ~p; i_key_stop = ~s;
        repeat (10) @(negedge i_clk);
        i_key_rec = 1'b1; i_key_play = 1'b1; i_key_stop = 1'b1;
        repeat (8) @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b0; i_key_rec = 1'b1; i_key_play = 1'b1; i_key_stop = 1'b1;
        i_init_done = 1'b0; i_slot_sel = '0; i_mode = 2'd0; i_speed = '0;
        i_rec_addr = '0; i_play_addr = '0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("reset_state", 32'(o_state), 32'(S_INIT));
        chk("reset_flags", 32'({o_rec_start, o_rec_stop, o_rec_pause, o_play_start, o_play_stop,
            o_play_en, o_play_fast, o_play_slow0, o_play_slow1, o_sram_wr}), 32'd0);
        chk("reset_regs", 32'({o_speed, o_base_addr, o_end_addr, o_slot_valid}), 32'd0);

        snap(); press(1'b1, 1'b0, 1'b0);
        chk("init_ignores_key", 32'(n_rs - b_rs), 32'd0);
        chk("init_hold", 32'(o_state), 32'(S_INIT));
        i_init_done = 1'b1;
        @(negedge i_clk);
        chk("init_to_idle", 32'(o_state), 32'(S_IDLE));

        // Slot 0 record: a held key yields a single start.
        snap(); press(1'b1, 1'b0, 1'b0);
        chk("t1_one_rec_start", 32'(n_rs - b_rs), 32'd1);
        chk("t1_state", 32'(o_state), 32'(S_REC));
        chk("t1_base", 32'(o_base_addr), 32'h00);
        chk("t1_end", 32'(o_end_addr), 32'd63);
        chk("t1_sram_wr", 32'(o_sram_wr), 32'd1);
        snap(); press(1'b0, 1'b0, 1'b1);
        chk("t1_rec_stop", 32'(n_rp - b_rp), 32'd1);
        chk("t1_empty_not_valid", 32'(o_slot_valid), 32'b0000);
        chk("t1_sram_rd", 32'(o_sram_wr), 32'd0);

        // Slot 2 record to 0x85, then play it back.
        i_slot_sel = 2'd2; i_rec_addr = 8'h80;
        press(1'b1, 1'b0, 1'b0);
        chk("t2_state_rec", 32'(o_state), 32'(S_REC));
        chk("t2_base", 32'(o_base_addr), 32'h80);
        chk("t2_last", 32'(o_end_addr), 32'hBF);
        i_rec_addr = 8'h85;
        snap(); press(1'b0, 1'b0, 1'b1);
        chk("t2_rec_stop", 32'(n_rp - b_rp), 32'd1);
        chk("t2_valid", 32'(o_slot_valid), 32'b0100);
        chk("t2_idle", 32'(o_state), 32'(S_IDLE));
        i_play_addr = 8'h00;
        snap(); press(1'b0, 1'b1, 1'b0);
        chk("t2_play_start", 32'(n_ps - b_ps), 32'd1);
        chk("t2_state_play", 32'(o_state), 32'(S_PLAY));
        chk("t2_play_end", 32'(o_end_addr), 32'h85);
        chk("t2_play_en", 32'(o_play_en), 32'd1);
        chk("t2_speed_norm", 32'(o_speed), 32'd1);
        chk("t2_mode_norm", 32'({o_play_fast, o_play_slow0, o_play_slow1}), 32'b000);
        stop_at = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge i_clk);
            if (o_play_stop) begin stop_at = i_play_addr; break; end
            i_play_addr = 8'h80 + 8'(i);
        end
        chk("t2_auto_play_stop_addr", 32'(stop_at), 32'h85);
        chk("t2_after_play", 32'({o_state, o_play_en}), 32'({S_IDLE, 1'b0}));

        // Slot 1 records until the region fills.
        i_slot_sel = 2'd1; i_rec_addr = 8'h40; i_play_addr = 8'h00;
        press(1'b1, 1'b0, 1'b0);
        chk("t3_state_rec", 32'(o_state), 32'(S_REC));
        stop_at = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_rec_stop) begin stop_at = i_rec_addr; break; end
            i_rec_addr = 8'h41 + 8'(i);
        end
        chk("t3_auto_rec_stop_addr", 32'(stop_at), 32'h7F);
        chk("t3_idle", 32'(o_state), 32'(S_IDLE));
        chk("t3_valid", 32'(o_slot_valid), 32'b0110);
        i_rec_addr = 8'h00;
        press(1'b0, 1'b1, 1'b0);
        chk("t3_play_end", 32'(o_end_addr), 32'h7F);
        chk("t3_play_base", 32'(o_base_addr), 32'h40);
        snap(); press(1'b0, 1'b0, 1'b1);
        chk("t3_play_stop", 32'(n_pp - b_pp), 32'd1);

        // Empty slot 3 cannot be played.
        i_slot_sel = 2'd3;
        snap(); press(1'b0, 1'b1, 1'b0);
        chk("t4_no_play_start", 32'(n_ps - b_ps), 32'd0);
        chk("t4_idle", 32'(o_state), 32'(S_IDLE));

        // Fast mode with speed 0, pause, new speed on resume.
        i_slot_sel = 2'd2; i_mode = 2'd1; i_speed = 4'd0;
        press(1'b0, 1'b1, 1'b0);
        chk("t5_mode_fast", 32'({o_play_fast, o_play_slow0, o_play_slow1}), 32'b100);
        chk("t5_speed0_is_1", 32'(o_speed), 32'd1);
        press(1'b0, 1'b1, 1'b0);
        chk("t5_paused", 32'({o_state, o_play_en, o_play_fast}), 32'({S_PPAUSE, 1'b0, 1'b1}));
        i_speed = 4'd5; i_slot_sel = 2'd0;
        press(1'b0, 1'b1, 1'b0);
        chk("t5_resumed", 32'(o_state), 32'(S_PLAY));
        chk("t5_speed5", 32'(o_speed), 32'd5);
        chk("t5_slot_sel_ignored", 32'(o_base_addr), 32'h80);
        press(1'b0, 1'b0, 1'b1);
        chk("t5_mode_cleared", 32'({o_state, o_play_fast}), 32'({S_IDLE, 1'b0}));

        // Stop beats rec in the same cycle; then reset mid-play.
        i_slot_sel = 2'd0; i_mode = 2'd0; i_rec_addr = 8'h00;
        press(1'b1, 1'b0, 1'b0);
        i_rec_addr = 8'h10;
        press(1'b1, 1'b0, 1'b0);
        chk("t6_rec_pause", 32'({o_state, o_rec_pause, o_sram_wr}), 32'({S_RPAUSE, 1'b1, 1'b0}));
        snap(); press(1'b1, 1'b0, 1'b1);
        chk("t6_stop_wins", 32'(o_state), 32'(S_IDLE));
        chk("t6_stop_pulse", 32'(n_rp - b_rp), 32'd1);
        chk("t6_no_restart", 32'(n_rs - b_rs), 32'd0);
        chk("t6_valid", 32'(o_slot_valid), 32'b0111);
        i_play_addr = 8'h00;
        press(1'b0, 1'b1, 1'b0);
        chk("t6_play", 32'({o_state, o_end_addr}), 32'({S_PLAY, 8'h10}));
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(o_state), 32'(S_INIT));
        chk("t6_rst_flags", 32'({o_rec_start, o_rec_stop, o_rec_pause, o_play_start, o_play_stop,
            o_play_en, o_play_fast, o_play_slow0, o_play_slow1, o_sram_wr}), 32'd0);
        chk("t6_rst_regs", 32'({o_speed, o_base_addr, o_end_addr, o_slot_valid}), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
Parametrised record/playback controller for the WM8731 audio path. It replaces the single-buffer key FSM with several things: debounced key events, NUM_SLOTS independent SRAM recording regions, record pause/resume, and latched playback mode and speed. It sits between the board keys and switches on one side and the AudRecorder, AudDSP and AudPlayer blocks on the other. It owns SRAM direction selection and the per-slot end addresses.

Parameters:
ADDR_W, 20, SRAM word-address width
NUM_SLOTS, 4, recording regions; must be a power of 2 and ≥2
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived)
SPEED_W, 4, speed factor width
DEB_CYCLES, 50000, cycles a synchronised key level must be stable before it is accepted

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  async active-low reset
i_key_rec  in  1  raw key, active-low
i_key_play  in  1  raw key, active-low
i_key_stop  in  1  raw key, active-low
i_init_done  in  1  I2C codec init complete (level)
i_slot_sel  in  SLOT_W  slot for the next record/play
i_mode  in  2  0 normal, 1 fast, 2 slow0 (constant interpolation), 3 slow1 (linear interpolation)
i_speed  in  SPEED_W  speed factor
i_rec_addr  in  ADDR_W  recorder current write address
i_play_addr  in  ADDR_W  DSP current read address
o_state  out  3  current FSM state
o_rec_start, o_rec_stop  out  1  one-cycle pulses to recorder
o_rec_pause  out  1  level: recorder paused
o_play_start, o_play_stop  out  1  one-cycle pulses to DSP
o_play_en  out  1  level: DSP/player running
o_play_fast, o_play_slow0, o_play_slow1  out  1  latched mode levels (one-hot or all 0)
o_speed  out  SPEED_W  latched speed
o_base_addr  out  ADDR_W  start address of the active slot
o_end_addr  out  ADDR_W  record limit (REC) or play limit (PLAY)
o_sram_wr  out  1  1 = recorder drives SRAM (WE_N low, DQ driven)
o_slot_valid  out  NUM_SLOTS  slot holds a recording

Behaviour:
- Reset is asynchronous on i_rst_n, active-low; clock is i_clk. On reset all outputs are 0, state is INIT, and all slot_valid and end registers clear. Reset mid-record or mid-play aborts immediately; no stop pulse is issued.
- Keys: 2-FF synchroniser, then a stability counter (DEB_CYCLES), then a one-cycle event on the debounced 1→0 (press) edge. A held key produces exactly one event.
- Simultaneous events priority: stop > rec > play. Lower-priority events in that cycle are dropped.
- Slot region: size = 2^(ADDR_W-SLOT_W); base = slot << (ADDR_W-SLOT_W); last = base + size - 1.
- States and transitions. Every transition takes effect at the edge after the event. Pulses are registered and coincide with the new state.
  - INIT→IDLE when i_init_done=1. Key events in INIT are ignored.
  - IDLE, rec event: latch slot, go to REC, pulse o_rec_start. o_base_addr = base, o_end_addr = last.
  - IDLE, play event: if o_slot_valid[i_slot_sel] is set, latch slot/mode/speed, go to PLAY, pulse o_play_start. Otherwise ignore the event.
  - REC, rec event: go to REC_PAUSE (o_rec_pause=1). REC_PAUSE, rec event: return to REC (o_rec_pause=0).
  - REC or REC_PAUSE, stop event: go to IDLE, pulse o_rec_stop, end[slot] = i_rec_addr, set slot_valid[slot] if i_rec_addr≠base.
  - REC with i_rec_addr==last: automatic stop. Same as a stop event, but end[slot] = last.
  - PLAY, play event: go to PLAY_PAUSE (o_play_en=0). PLAY_PAUSE, play event: return to PLAY and re-latch mode/speed.
  - PLAY or PLAY_PAUSE, stop event: go to IDLE, pulse o_play_stop.
  - PLAY with i_play_addr ≥ end[slot]: automatic stop. Same as a stop event.
- o_sram_wr = 1 only in REC. o_play_en = 1 only in PLAY.
- Mode/speed latch: o_speed = 1 when mode is normal or i_speed = 0; otherwise o_speed = i_speed. Mode levels are held through PLAY_PAUSE and cleared on entry to IDLE.
- Re-recording a valid slot overwrites its end register at stop.
- i_slot_sel changes outside IDLE are ignored.

Decomposition:
- Package rec_play_pkg: state enum (INIT, IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE) and mode enum (NORMAL, FAST, SLOW0, SLOW1).
- Sub-module key_debounce (parameter DEB_CYCLES), instantiated three times.

Test Plan:
All scenarios use ADDR_W=8, NUM_SLOTS=4 (64-word slots) and DEB_CYCLES=4.
1. Reset, then i_init_done=1 → state IDLE at the next edge. Then hold rec key 10 cycles → exactly one o_rec_start, o_base_addr=0, o_end_addr=63, o_sram_wr=1.
2. Slot 2 record: rec event, then drive i_rec_addr=0x85, then stop → o_rec_stop pulse, slot_valid=4'b0100, end=0x85. Play slot 2 with i_play_addr ramping → auto o_play_stop at 0x85.
3. Record slot 1 and never stop, with i_rec_addr ramping → auto stop at i_rec_addr=0x7F, end=0x7F.
4. Play event on slot 3 with slot_valid[3]=0 → no pulse, state stays IDLE.
5. PLAY with mode=1, speed=0 → o_play_fast=1, o_speed=1. Pause, set speed=5, resume → o_speed=5.
6. Stop and rec pressed in the same cycle during REC_PAUSE → stop wins, state IDLE. Assert reset mid-PLAY → all outputs 0, state INIT.
